time_set_entry: RTL and testbench

TIME_SET_ENTRY -- requirements
Module: time_set_entry

---
 rtl/time_set_entry.sv | 171 +++++++++++++++++
 tb/tb_time_set_entry.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/time_set_entry.sv
// Button-driven hour/minute editor: three raw buttons are synchronized and debounced,
// then drive an IDLE -> SET_HOUR -> SET_MIN -> COMMIT edit sequence.

module tse_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic main_clock,
    input  logic reset,
    input  logic btn_i,
    output logic press_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q, level_q, press_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    // Count consecutive disagreeing cycles; any agreement restarts the count.
    always_comb begin
        accept = 1'b0;
        cnt_d  = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) accept = 1'b1;
            else                                   cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            if (accept) level_q <= sync2_q;
            press_q <= accept & sync2_q;
        end
    end

    assign press_o = press_q;
endmodule

module time_set_entry #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int TIMEOUT_CYCLES  = 1000000000
) (
    input  logic        main_clock,
    input  logic        reset,
    input  logic        btn_mode,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic [16:0] cur_time,
    output logic [16:0] time_set,
    output logic        time_load,
    output logic [1:0]  edit_field
);
    localparam int NUM_BTN = 3;
    localparam int TW      = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, SET_HOUR, SET_MIN, COMMIT} state_t;

    logic [NUM_BTN-1:0] btn_raw, press;
    logic               p_mode, inc, dec, any_press;

    assign btn_raw = {btn_down, btn_up, btn_mode};

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        tse_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
            .main_clock (main_clock),
            .reset      (reset),
            .btn_i      (btn_raw[i]),
            .press_o    (press[i])
        );
    end

    // Mode wins over up/down; simultaneous up+down cancel each other.
    assign p_mode    = press[0];
    assign inc       = press[1] & ~press[2] & ~p_mode;
    assign dec       = press[2] & ~press[1] & ~p_mode;
    assign any_press = |press;

    state_t        state_q, state_d;
    logic [4:0]    hours_q, hours_d, seed_h;
    logic [5:0]    mins_q, mins_d, seed_m;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [16:0]   time_set_q, time_set_d;
    logic          time_load_q;
    logic [1:0]    edit_field_q, edit_field_d;

    always_comb begin
        seed_h = '0;
        seed_m = '0;
        if (cur_time < 17'd86400) begin
            seed_h = 5'(cur_time / 17'd3600);
            seed_m = 6'((cur_time % 17'd3600) / 17'd60);
        end
    end

    always_comb begin
        state_d    = state_q;
        hours_d    = hours_q;
        mins_d     = mins_q;
        tmo_d      = '0;
        time_set_d = time_set_q;
        unique case (state_q)
            IDLE: begin
                if (p_mode) begin
                    state_d = SET_HOUR;
                    hours_d = seed_h;
                    mins_d  = seed_m;
                end
            end
            SET_HOUR: begin
                if (p_mode)   state_d = SET_MIN;
                else if (inc) hours_d = (hours_q == 5'd23) ? 5'd0 : hours_q + 5'd1;
                else if (dec) hours_d = (hours_q == 5'd0) ? 5'd23 : hours_q - 5'd1;
            end
            SET_MIN: begin
                if (p_mode)   state_d = COMMIT;
                else if (inc) mins_d = (mins_q == 6'd59) ? 6'd0 : mins_q + 6'd1;
                else if (dec) mins_d = (mins_q == 6'd0) ? 6'd59 : mins_q - 6'd1;
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Inactivity abandons the edit; any press, even a cancelled one, restarts the wait.
        if (state_q == SET_HOUR || state_q == SET_MIN) begin
            if (any_press)                              tmo_d   = '0;
            else if (tmo_q == TW'(TIMEOUT_CYCLES - 1))  state_d = IDLE;
            else                                        tmo_d   = tmo_q + TW'(1);
        end

        if (state_d == COMMIT)
            time_set_d = 17'(hours_d) * 17'd3600 + 17'(mins_d) * 17'd60;

        unique case (state_d)
            SET_HOUR: edit_field_d = 2'b01;
            SET_MIN:  edit_field_d = 2'b10;
            default:  edit_field_d = 2'b00;
        endcase
    end

    always_ff @(posedge main_clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hours_q      <= '0;
            mins_q       <= '0;
            tmo_q        <= '0;
            time_set_q   <= '0;
            time_load_q  <= 1'b0;
            edit_field_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            hours_q      <= hours_d;
            mins_q       <= mins_d;
            tmo_q        <= tmo_d;
            time_set_q   <= time_set_d;
            time_load_q  <= (state_d == COMMIT);
            edit_field_q <= edit_field_d;
        end
    end

    assign time_set   = time_set_q;
    assign time_load  = time_load_q;
    assign edit_field = edit_field_q;
endmodule

// File: tb/tb_time_set_entry.sv
// Directed bench for time_set_entry with short debounce/timeout parameters.

module tb_time_set_entry;
    localparam int DEB = 4;
    localparam int TMO = 100;

    logic        main_clock = 1'b0;
    logic        reset      = 1'b1;
    logic        btn_mode   = 1'b0;
    logic        btn_up     = 1'b0;
    logic        btn_down   = 1'b0;
    logic [16:0] cur_time   = 17'd0;
    logic [16:0] time_set;
    logic        time_load;
    logic [1:0]  edit_field;

    int          n_vec    = 0;
    int          n_err    = 0;
    int          load_cnt = 0;
    logic [16:0] last_set = 17'd0;

    always #5 main_clock = ~main_clock;

    time_set_entry #(.DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO)) dut (
        .main_clock (main_clock),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .cur_time   (cur_time),
        .time_set   (time_set),
        .time_load  (time_load),
        .edit_field (edit_field)
    );

    // Every high cycle of time_load counts, so a stretched strobe shows up as extra loads.
    always @(negedge main_clock) begin
        if (time_load === 1'b1) begin
            load_cnt = load_cnt + 1;
            last_set = time_set;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge main_clock);
    endtask

    task automatic press(input logic m, input logic u, input logic d);
        btn_mode = m; btn_up = u; btn_down = d;
        cycles(10);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        cycles(10);
    endtask

    task automatic test_reset;
        cycles(3);
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL reset_edit_field got %b want 00", edit_field); end
        n_vec++; if (time_load !== 1'b0) begin n_err++; $display("FAIL reset_time_load got %b want 0", time_load); end
        n_vec++; if (time_set !== 17'd0) begin n_err++; $display("FAIL reset_time_set got %0d want 0", time_set); end
        reset = 1'b0;
        cycles(3);
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL post_reset_edit_field got %b want 00", edit_field); end
    endtask

    task automatic test_bounce;
        int base;
        base = load_cnt;
        cur_time = 17'd45296;
        btn_mode = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycles(2);
            btn_mode = ~btn_mode;
        end
        btn_mode = 1'b1;
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL bounce_rejected got %b want 00", edit_field); end
        cycles(10);
        n_vec++; if (edit_field !== 2'b01) begin n_err++; $display("FAIL bounce_accept got %b want 01", edit_field); end
        btn_mode = 1'b0;
        cycles(10);
        press(1, 0, 0);
        n_vec++; if (edit_field !== 2'b10) begin n_err++; $display("FAIL bounce_single_press got %b want 10", edit_field); end
        press(1, 0, 0);
        n_vec++; if (load_cnt - base !== 1) begin n_err++; $display("FAIL bounce_loads got %0d want 1", load_cnt - base); end
        n_vec++; if (last_set !== 17'd45240) begin n_err++; $display("FAIL bounce_seed got %0d want 45240", last_set); end
    endtask

    task automatic test_full_edit;
        int base;
        base = load_cnt;
        cur_time = 17'd45296;
        press(1, 0, 0);
        n_vec++; if (edit_field !== 2'b01) begin n_err++; $display("FAIL full_hour_field got %b want 01", edit_field); end
        for (int i = 0; i < 12; i++) press(0, 1, 0);
        press(1, 0, 0);
        n_vec++; if (edit_field !== 2'b10) begin n_err++; $display("FAIL full_min_field got %b want 10", edit_field); end
        for (int i = 0; i < 35; i++) press(0, 0, 1);
        n_vec++; if (load_cnt - base !== 0) begin n_err++; $display("FAIL full_early_load got %0d want 0", load_cnt - base); end
        press(1, 0, 0);
        n_vec++; if (load_cnt - base !== 1) begin n_err++; $display("FAIL full_loads got %0d want 1", load_cnt - base); end
        n_vec++; if (last_set !== 17'd3540) begin n_err++; $display("FAIL full_value got %0d want 3540", last_set); end
        n_vec++; if (time_set !== 17'd3540) begin n_err++; $display("FAIL full_hold got %0d want 3540", time_set); end
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL full_idle got %b want 00", edit_field); end
    endtask

    task automatic test_wrap;
        int base;
        base = load_cnt;
        cur_time = 17'd86399;
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        n_vec++; if (load_cnt - base !== 1) begin n_err++; $display("FAIL wrap_loads got %0d want 1", load_cnt - base); end
        n_vec++; if (last_set !== 17'd0) begin n_err++; $display("FAIL wrap_value got %0d want 0", last_set); end
    endtask

    task automatic test_invalid_seed;
        int base;
        base = load_cnt;
        cur_time = 17'd100000;
        press(1, 0, 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        n_vec++; if (load_cnt - base !== 1) begin n_err++; $display("FAIL bad_seed_loads got %0d want 1", load_cnt - base); end
        n_vec++; if (last_set !== 17'd3600) begin n_err++; $display("FAIL bad_seed_value got %0d want 3600", last_set); end
    endtask

    task automatic test_timeout;
        int base;
        base = load_cnt;
        cur_time = 17'd45296;
        press(1, 0, 0);
        press(1, 0, 0);
        cycles(60);
        n_vec++; if (edit_field !== 2'b10) begin n_err++; $display("FAIL timeout_early got %b want 10", edit_field); end
        cycles(50);
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL timeout_idle got %b want 00", edit_field); end
        n_vec++; if (load_cnt - base !== 0) begin n_err++; $display("FAIL timeout_loads got %0d want 0", load_cnt - base); end
        n_vec++; if (time_set !== 17'd3600) begin n_err++; $display("FAIL timeout_time_set got %0d want 3600", time_set); end
    endtask

    task automatic test_conflict;
        int base;
        base = load_cnt;
        cur_time = 17'd45296;
        press(1, 0, 0);
        press(0, 1, 1);
        n_vec++; if (edit_field !== 2'b01) begin n_err++; $display("FAIL conflict_updown_field got %b want 01", edit_field); end
        press(1, 1, 0);
        n_vec++; if (edit_field !== 2'b10) begin n_err++; $display("FAIL conflict_mode_up_field got %b want 10", edit_field); end
        press(1, 0, 0);
        n_vec++; if (load_cnt - base !== 1) begin n_err++; $display("FAIL conflict_loads got %0d want 1", load_cnt - base); end
        n_vec++; if (last_set !== 17'd45240) begin n_err++; $display("FAIL conflict_value got %0d want 45240", last_set); end
    endtask

    task automatic test_reset_mid_edit;
        int base;
        base = load_cnt;
        cur_time = 17'd45296;
        press(1, 0, 0);
        press(1, 0, 0);
        n_vec++; if (edit_field !== 2'b10) begin n_err++; $display("FAIL rst_edit_setmin got %b want 10", edit_field); end
        #3 reset = 1'b1;
        #1;
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL rst_async_field got %b want 00", edit_field); end
        n_vec++; if (time_set !== 17'd0) begin n_err++; $display("FAIL rst_async_time_set got %0d want 0", time_set); end
        n_vec++; if (time_load !== 1'b0) begin n_err++; $display("FAIL rst_async_time_load got %b want 0", time_load); end
        cycles(3);
        reset = 1'b0;
        press(1, 0, 0);
        cycles(30);
        n_vec++; if (load_cnt - base !== 0) begin n_err++; $display("FAIL rst_no_load got %0d want 0", load_cnt - base); end
        n_vec++; if (edit_field !== 2'b01) begin n_err++; $display("FAIL rst_fresh_edit got %b want 01", edit_field); end
    endtask

    task automatic test_held_reset;
        int base;
        base = load_cnt;
        reset = 1'b1;
        btn_mode = 1'b1;
        cycles(3);
        reset = 1'b0;
        cycles(3);
        n_vec++; if (edit_field !== 2'b00) begin n_err++; $display("FAIL held_too_early got %b want 00", edit_field); end
        cycles(7);
        n_vec++; if (edit_field !== 2'b01) begin n_err++; $display("FAIL held_press got %b want 01", edit_field); end
        btn_mode = 1'b0;
        cycles(20);
        n_vec++; if (edit_field !== 2'b01) begin n_err++; $display("FAIL held_single got %b want 01", edit_field); end
        n_vec++; if (load_cnt - base !== 0) begin n_err++; $display("FAIL held_loads got %0d want 0", load_cnt - base); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_full_edit();
        test_wrap();
        test_invalid_seed();
        test_timeout();
        test_conflict();
        test_reset_mid_edit();
        test_held_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
